// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce
//  Description : Synchronises and debounces the raw board slide switches for
//                the processor's general-purpose input port. Each channel has
//                a SYNC_STAGES-deep synchroniser followed by a debounce
//                counter. A new level is accepted only after DB_COUNT
//                consecutive enabled samples that differ from the current
//                output.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous reset, active low
//                sample_en  - debounce sample strobe
//                sw_in      - raw asynchronous switch levels [WIDTH]
//                sw_out     - debounced levels [WIDTH]
//                sw_rise    - one-cycle pulse, sw_out bit went 0->1 [WIDTH]
//                sw_fall    - one-cycle pulse, sw_out bit went 1->0 [WIDTH]
//                changed    - one-cycle pulse, any sw_out bit changed
//                stable     - all channels settled, no change pending
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed,
  output logic             stable
);

  localparam int                 c_cnt_w    = $clog2(DB_COUNT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_COUNT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // Reject configurations that cannot work at elaboration time.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("switch_debounce: SYNC_STAGES must be >= 2");
  end
  if (DB_COUNT < 1) begin : g_bad_db_count
    $error("switch_debounce: DB_COUNT must be >= 1");
  end

  // --------------------------------------------------------------------------
  // Synchroniser: free-running shift, independent of sample_en.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Per-channel debounce counters.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_flip;
  logic [WIDTH-1:0] w_cnt_zero;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_diff;

    assign w_diff        = (w_s[i] != r_out[i]);
    // The final differing sample flips the output rather than incrementing,
    // so the counter never exceeds DB_COUNT-1.
    assign w_flip[i]     = sample_en && w_diff && (r_cnt == c_cnt_last);
    assign w_cnt_zero[i] = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (sample_en) begin
        if (!w_diff || (r_cnt == c_cnt_last)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output level and edge pulses. A flipping bit always differs from its
  // current value, so XOR with w_flip loads the synchronised level.
  // w_flip is already gated by sample_en, so pulses drop to 0 when idle.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out     <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_out     <= r_out ^ w_flip;
      r_rise    <= w_flip & w_s;
      r_fall    <= w_flip & ~w_s;
      r_changed <= |w_flip;
    end
  end

  assign sw_out  = r_out;
  assign sw_rise = r_rise;
  assign sw_fall = r_fall;
  assign changed = r_changed;
  // Decoded from flops only; a pending count or an unsettled input clears it.
  assign stable  = (w_s == r_out) && (&w_cnt_zero);

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debounce
//  Description : Directed self-checking bench for switch_debounce with
//                WIDTH=5, SYNC_STAGES=2, DB_COUNT=4. Edge numbering: inputs
//                are changed 1 time unit after "edge 0"; checks are made
//                1 time unit after each following rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b1;
  logic [4:0] sw_in = 5'd0;
  logic [4:0] sw_out;
  logic [4:0] sw_rise;
  logic [4:0] sw_fall;
  logic       changed;
  logic       stable;

  int checks = 0;
  int errors = 0;

  switch_debounce #(
    .WIDTH       (5),
    .SYNC_STAGES (2),
    .DB_COUNT    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .sw_in     (sw_in),
    .sw_out    (sw_out),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .changed   (changed),
    .stable    (stable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [4:0] exp_out, input logic exp_stable);
    chk({tag, "/out"},     32'(sw_out),  32'(exp_out));
    chk({tag, "/rise"},    32'(sw_rise), 32'd0);
    chk({tag, "/fall"},    32'(sw_fall), 32'd0);
    chk({tag, "/changed"}, 32'(changed), 32'd0);
    chk({tag, "/stable"},  32'(stable),  32'(exp_stable));
  endtask

  // Clean step on sw_in with sample_en held high: flip expected at edge 6,
  // stable low after edges 2..5 when a change is pending.
  task automatic apply(input string tag, input logic [4:0] nw, input logic [4:0] old);
    logic pending;
    logic [4:0] exp_out;
    logic [4:0] exp_rise;
    logic [4:0] exp_fall;
    pending = (nw != old);
    sw_in = nw;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_out  = (e >= 6) ? nw : old;
      exp_rise = (e == 6) ? (nw & ~old) : 5'd0;
      exp_fall = (e == 6) ? (old & ~nw) : 5'd0;
      chk($sformatf("%s/out@%0d", tag, e),     32'(sw_out),  32'(exp_out));
      chk($sformatf("%s/rise@%0d", tag, e),    32'(sw_rise), 32'(exp_rise));
      chk($sformatf("%s/fall@%0d", tag, e),    32'(sw_fall), 32'(exp_fall));
      chk($sformatf("%s/changed@%0d", tag, e), 32'(changed), 32'((e == 6) && pending));
      chk($sformatf("%s/stable@%0d", tag, e),  32'(stable),  32'(!(pending && e >= 2 && e <= 5)));
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    #1 rst = 1'b0;
    #1 chk_idle("reset_async", 5'd0, 1'b1);
    tick();
    tick();
    chk_idle("reset_held", 5'd0, 1'b1);
    rst = 1'b1;
    tick();
    chk_idle("reset_release", 5'd0, 1'b1);
    tick();

    // ---------------- test 1: single rising channel ----------------
    apply("t1_rise0", 5'b00001, 5'b00000);
    apply("t1_fall0", 5'b00000, 5'b00001);

    // ---------------- test 2: bounce then settle ----------------
    for (int e = 0; e <= 30; e++) begin
      if (e > 0) begin
        tick();
        chk($sformatf("t2/out@%0d", e),     32'(sw_out),  32'((e >= 26) ? 5'b00001 : 5'b00000));
        chk($sformatf("t2/rise@%0d", e),    32'(sw_rise), 32'((e == 26) ? 5'b00001 : 5'b00000));
        chk($sformatf("t2/changed@%0d", e), 32'(changed), 32'(e == 26));
      end
      sw_in[0] = (e < 20) ? (((e / 2) % 2) == 0) : 1'b1;
    end
    apply("t2_restore", 5'b00000, 5'b00001);

    // ---------------- test 3: several channels together ----------------
    apply("t3_multi", 5'b10101, 5'b00000);

    // ---------------- test 5: single falling channel ----------------
    apply("t5_all", 5'b11111, 5'b10101);
    apply("t5_fall4", 5'b01111, 5'b11111);
    apply("t5_clear", 5'b00000, 5'b01111);

    // ---------------- test 4: sample_en every third clock ----------------
    sw_in = 5'b00010;
    sample_en = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk($sformatf("t4/out@%0d", e),     32'(sw_out),  32'((e >= 12) ? 5'b00010 : 5'b00000));
      chk($sformatf("t4/rise@%0d", e),    32'(sw_rise), 32'((e == 12) ? 5'b00010 : 5'b00000));
      chk($sformatf("t4/changed@%0d", e), 32'(changed), 32'(e == 12));
      sample_en = (((e + 1) % 3) == 0);
    end
    sample_en = 1'b1;
    tick();
    chk_idle("t4_settled", 5'b00010, 1'b1);

    // ---------------- test 6: reset mid-count ----------------
    sw_in = 5'b00011;
    for (int e = 1; e <= 4; e++) begin
      tick();
    end
    chk("t6/stable_pending", 32'(stable), 32'd0);
    rst = 1'b0;
    #2 chk_idle("t6_in_reset", 5'd0, 1'b1);
    tick();
    tick();
    chk_idle("t6_reset_hold", 5'd0, 1'b1);
    rst = 1'b1;
    apply("t6_after", 5'b00011, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
